// File: rtl/rx_packet_receiver_if.sv
// Link-side bundle for the RX packet receiver: serial input from the bit sampler
// and the reassembled packet/status toward the display logic.
interface rx_packet_receiver_if;
  logic         rx_sof;
  logic         rx_valid;
  logic         rx_bit;
  logic [135:0] rx_packet;
  logic         pkt_valid;
  logic         crc_err;
  logic         busy;
  logic [1:0]   flag_status;

  modport master (
    output rx_sof, rx_valid, rx_bit,
    input  rx_packet, pkt_valid, crc_err, busy, flag_status
  );

  modport slave (
    input  rx_sof, rx_valid, rx_bit,
    output rx_packet, pkt_valid, crc_err, busy, flag_status
  );
endinterface

// File: rtl/rx_packet_receiver.sv
// Serial RX frame deserializer: header, payload, CRC-8 check and destination filter,
// publishing accepted packets in the TX-side 136-bit layout.
module rx_packet_receiver #(
  parameter int          MAX_BYTES = 15,
  parameter logic [7:0]  CRC_POLY  = 8'h07
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           my_id,
  rx_packet_receiver_if.slave  link
);
  localparam int ASM_W = MAX_BYTES * 8;
  localparam int PAD_W = 128 - ASM_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CRC,
    S_DROP
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       sr;
  logic [7:0]       sr_in;
  logic [7:0]       hdr;
  logic [2:0]       bit_cnt;
  logic [3:0]       byte_cnt;
  logic [ASM_W-1:0] asm_r;
  logic [7:0]       crc;
  logic [135:0]     pkt_r;
  logic             pkt_valid_r;
  logic             crc_err_r;
  logic [1:0]       flags_r;
  logic [6:0]       byte_base;

  logic sof_hit, last_bit;
  logic hdr_done, byte_done, crc_done, drop_byte;
  logic [3:0] len;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  assign sof_hit  = link.rx_sof & link.rx_valid;
  assign last_bit = (bit_cnt == 3'd7);
  assign sr_in    = {sr[6:0], link.rx_bit};
  assign len      = hdr[3:0];
  // Byte k of the payload lands at the k-th byte from the top of the assembly register.
  assign byte_base = 7'((MAX_BYTES - 1 - int'(byte_cnt)) * 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hdr_done  = 1'b0;
    byte_done = 1'b0;
    crc_done  = 1'b0;
    drop_byte = 1'b0;
    if (sof_hit) begin
      state_nxt = S_HEADER;
    end else if (link.rx_valid) begin
      case (state)
        S_HEADER: if (last_bit) begin
          hdr_done = 1'b1;
          if (sr_in[7:6] != my_id)    state_nxt = S_DROP;
          else if (sr_in[3:0] == 4'd0) state_nxt = S_CRC;
          else                         state_nxt = S_PAYLOAD;
        end
        S_PAYLOAD: if (last_bit) begin
          byte_done = 1'b1;
          if (byte_cnt == len - 4'd1) state_nxt = S_CRC;
        end
        S_CRC: if (last_bit) begin
          crc_done  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_DROP: if (last_bit) begin
          drop_byte = 1'b1;
          // Payload bytes plus the CRC byte: len+1 bytes in total.
          if (byte_cnt == len) state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '0;
      hdr         <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      asm_r       <= '0;
      crc         <= '0;
      pkt_r       <= '0;
      pkt_valid_r <= 1'b0;
      crc_err_r   <= 1'b0;
      flags_r     <= '0;
    end else begin
      pkt_valid_r <= 1'b0;
      crc_err_r   <= 1'b0;
      if (sof_hit) begin
        // A valid sof always restarts, even mid-frame; it is header bit 7.
        sr       <= {7'd0, link.rx_bit};
        bit_cnt  <= 3'd1;
        byte_cnt <= '0;
        asm_r    <= '0;
        crc      <= crc_step(8'h00, link.rx_bit);
        flags_r  <= '0;
      end else if (link.rx_valid && state != S_IDLE) begin
        sr      <= sr_in;
        bit_cnt <= bit_cnt + 3'd1;
        if (state == S_HEADER || state == S_PAYLOAD)
          crc <= crc_step(crc, link.rx_bit);
        if (hdr_done) begin
          hdr        <= sr_in;
          flags_r[1] <= 1'b1;
        end
        if (byte_done) begin
          asm_r[byte_base +: 8] <= sr_in;
          byte_cnt              <= byte_cnt + 4'd1;
        end
        if (drop_byte)
          byte_cnt <= byte_cnt + 4'd1;
        if (crc_done) begin
          if (sr_in == crc) begin
            pkt_r       <= {hdr, asm_r, {PAD_W{1'b0}}};
            pkt_valid_r <= 1'b1;
            flags_r[0]  <= 1'b1;
          end else begin
            crc_err_r <= 1'b1;
          end
        end
      end
    end
  end

  assign link.rx_packet   = pkt_r;
  assign link.pkt_valid   = pkt_valid_r;
  assign link.crc_err     = crc_err_r;
  assign link.busy        = (state != S_IDLE);
  assign link.flag_status = flags_r;
endmodule

// File: doc/rx_packet_receiver.md
Name: rx_packet_receiver

Overview:
- Receive-side counterpart of the TX packet path: deserializes a MSB-first serial frame (header byte, payload bytes, CRC-8) arriving from the link.
- Checks CRC and destination ID, then presents the reassembled packet in the same 136-bit layout the TX side builds.
- Sits between the link PHY/bit sampler and the RX display/LED logic.

Parameters:
- MAX_BYTES, 15, maximum payload bytes accepted. The length field is 4 bits, so the range is 0..15.
- CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1). Init value 8'h00, no reflection, no final XOR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- my_id  in  2  this node's ID, compared with header dest
- rx_sof  in  1  start-of-frame; valid only together with rx_valid; marks header bit 7
- rx_valid  in  1  qualifies rx_bit this cycle
- rx_bit  in  1  serial data, MSB first
- rx_packet  out  136  last accepted packet: [135:134] dest, [133:132] src, [131:128] length, [127:0] payload with byte0 at [127:120]; unused bytes zero
- pkt_valid  out  1  one-cycle pulse when rx_packet is updated
- crc_err  out  1  one-cycle pulse on CRC mismatch
- busy  out  1  high while state != IDLE
- flag_status  out  2  [1] header received (sticky), [0] good packet received (sticky); both cleared by the next rx_sof

Behaviour:
- Reset values: all outputs 0, state IDLE, assembly register 0, CRC 0, counters 0.
- Only cycles with rx_valid=1 advance the FSM, the shift register or the CRC. When rx_valid=0, everything holds.
- States:
  - IDLE: waits for rx_sof&rx_valid. That bit is header bit 7; go to HEADER.
  - HEADER: shifts 8 bits in total. On the 8th bit, latch the length. If dest!=my_id, go to DROP. Else if length==0, go to CRC. Else go to PAYLOAD. flag_status[1] sets on the 8th bit regardless of the address result.
  - PAYLOAD: collects length*8 bits. Byte k is written into [127-8k:120-8k] of the assembly register. A byte counter (4 bits) and a bit counter (3 bits) track position. After the last bit, go to CRC.
  - CRC: receives 8 CRC bits. After the 8th, compare against the running CRC.
    - Match: copy assembly to rx_packet, pulse pkt_valid, set flag_status[0].
    - Mismatch: pulse crc_err; rx_packet keeps its previous value.
    - Both cases return to IDLE.
  - DROP: consumes length*8+8 bits without updating rx_packet or asserting pulses, then returns to IDLE.
- CRC arithmetic: update over header and payload bits only, one bit per valid cycle: fb = crc[7]^rx_bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0). Cleared at every sof.
- Latency: pkt_valid and crc_err assert in the cycle after the clock edge that accepted the final CRC bit.
- rx_sof&rx_valid in any non-IDLE state aborts the current frame with no pulses. The frame restarts with that bit as header bit 7, and CRC, counters and assembly are cleared.
- rx_sof with rx_valid=0 is ignored.
- Assembly register is zeroed at sof, so unused payload bytes read 0.
- Asynchronous reset mid-frame: immediate return to reset values; rx_packet cleared.
- rx_packet is never partially updated; it changes only on a pkt_valid cycle.

Test Plan:
- Good 1-byte frame: my_id=01, bits 0x41,0xA5,0x3C contiguous -> pkt_valid pulse one cycle after 24th bit; rx_packet={8'h41,8'hA5,120'h0}; flag_status=2'b11; crc_err=0.
- Zero-length frame: my_id=01, bits 0x40,0xC7 -> pkt_valid after 16th bit; rx_packet={8'h40,128'h0}.
- CRC error: my_id=01, bits 0x41,0xA5,0x3D -> crc_err pulse; pkt_valid=0; rx_packet unchanged from previous; flag_status=2'b10.
- Address miss: my_id=10, frame 0x41,0xA5,0x3C -> no pulses; busy high for 24 valid bits, then low; rx_packet unchanged.
- Stall and abort: the good 1-byte frame with rx_valid toggled 1/0 every cycle gives the same result after 48 cycles. Separately, a new sof after 10 bits followed by 0x40,0xC7 gives exactly one pkt_valid with rx_packet={8'h40,128'h0}.
- Reset mid-frame: rst_n low after 12 bits -> all outputs 0 and busy 0 immediately; the next full good frame is accepted normally.
